// File: rtl/vga_pic_bounce.sv
// vga_pic_bounce
//   Pixel-data generator for vga_ctrl. It draws a solid square that moves
//   across the active area, bounces off the edges and changes colour on
//   every bounce. Motion state is updated only at frame end, so a frame
//   never tears.
//
//   Optional feature macro: VGA_PIC_BAR_BG_EN
//     defined   -> the background is 10 vertical colour bars.
//     undefined -> the background is the flat colour BG_COLOR.
//
// Ports
//   vga_clk    in   1   pixel clock, all logic on its rising edge
//   sys_rst_n  in   1   asynchronous active-low reset
//   pix_x      in  10   current column (10'h3FF outside the active area)
//   pix_y      in  10   current line   (10'h3FF outside the active area)
//   pix_data   out 16   registered RGB565 for the coordinate of the previous cycle
module vga_pic_bounce #(
  parameter int unsigned H_VALID   = 640,
  parameter int unsigned V_VALID   = 480,
  parameter int unsigned SQ_SIZE   = 64,
  parameter int unsigned STEP      = 2,
  parameter int unsigned FRAME_DIV = 1,
  parameter logic [15:0] BG_COLOR  = 16'h0000
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [15:0] pix_data
);

  localparam logic [9:0]  H_LAST    = 10'(H_VALID - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_VALID - 1);
  localparam logic [10:0] XMAX      = 11'(H_VALID - SQ_SIZE);
  localparam logic [10:0] YMAX      = 11'(V_VALID - SQ_SIZE);
  localparam logic [10:0] STEP_W    = 11'(STEP);
  localparam logic [10:0] SQ_W      = 11'(SQ_SIZE);
  localparam logic [10:0] H_W       = 11'(H_VALID);
  localparam logic [10:0] V_W       = 11'(V_VALID);
  localparam logic [7:0]  FDIV_LAST = 8'(FRAME_DIV - 1);

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;
    logic       hit;
  } axis_t;

  // One axis of the motion update; 11-bit arithmetic so pos+STEP cannot wrap.
  function automatic axis_t axis_step(input logic [9:0] pos, input logic dir,
                                      input logic [10:0] lim);
    logic [10:0] p;
    logic [10:0] s;
    logic [10:0] d;
    axis_t       r;
    p     = {1'b0, pos};
    s     = p + STEP_W;
    d     = p - STEP_W;
    r.pos = pos;
    r.dir = dir;
    r.hit = 1'b0;
    if (!dir) begin
      if (s >= lim) begin
        r.pos = lim[9:0];
        r.dir = 1'b1;
        r.hit = 1'b1;
      end else begin
        r.pos = s[9:0];
      end
    end else begin
      if (p <= STEP_W) begin
        r.pos = 10'd0;
        r.dir = 1'b0;
        r.hit = 1'b1;
      end else begin
        r.pos = d[9:0];
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] palette(input logic [2:0] i);
    logic [15:0] c;
    case (i)
      3'd0:    c = 16'hF800;
      3'd1:    c = 16'hFC00;
      3'd2:    c = 16'hFFE0;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'h07FF;
      3'd5:    c = 16'h001F;
      3'd6:    c = 16'hF81F;
      default: c = 16'hFFFF;
    endcase
    return c;
  endfunction

  logic [9:0]  x0, y0;
  logic        dir_x, dir_y;
  logic [2:0]  cidx;
  logic [7:0]  fdiv;
  logic        frame_end, upd;
  axis_t       ax, ay;

  assign frame_end = (pix_x == H_LAST) && (pix_y == V_LAST);
  assign upd       = frame_end && (fdiv == FDIV_LAST);
  assign ax        = axis_step(x0, dir_x, XMAX);
  assign ay        = axis_step(y0, dir_y, YMAX);

  // Motion state: the frame-end pixel is still rendered from the old values
  // because pix_data samples them on the same edge that updates them.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x0    <= '0;
      y0    <= '0;
      dir_x <= 1'b0;
      dir_y <= 1'b0;
      cidx  <= '0;
      fdiv  <= '0;
    end else if (frame_end) begin
      if (upd) begin
        fdiv  <= '0;
        x0    <= ax.pos;
        y0    <= ay.pos;
        dir_x <= ax.dir;
        dir_y <= ay.dir;
        // A corner hit still advances the colour only once.
        if (ax.hit || ay.hit) cidx <= cidx + 3'd1;
      end else begin
        fdiv <= fdiv + 8'd1;
      end
    end
  end

  logic [15:0] bg;

`ifdef VGA_PIC_BAR_BG_EN
  localparam logic [9:0] BAR_W = 10'(H_VALID / 10);

  function automatic logic [15:0] bar_color(input logic [3:0] i);
    logic [15:0] c;
    case (i)
      4'd0:    c = 16'hF800;
      4'd1:    c = 16'hFC00;
      4'd2:    c = 16'hFFE0;
      4'd3:    c = 16'h07E0;
      4'd4:    c = 16'h07FF;
      4'd5:    c = 16'h001F;
      4'd6:    c = 16'hF81F;
      4'd7:    c = 16'h0000;
      4'd8:    c = 16'hFFFF;
      default: c = 16'hD69A;
    endcase
    return c;
  endfunction

  logic [9:0] bar_q;
  logic [3:0] bar_idx;
  assign bar_q   = pix_x / BAR_W;
  assign bar_idx = (bar_q > 10'd9) ? 4'd9 : bar_q[3:0];
  assign bg      = bar_color(bar_idx);
`else
  assign bg = BG_COLOR;
`endif

  logic        outside, in_sq;
  logic [10:0] px, py, sx, sy;
  logic [15:0] pix_nxt;

  assign px      = {1'b0, pix_x};
  assign py      = {1'b0, pix_y};
  assign sx      = {1'b0, x0};
  assign sy      = {1'b0, y0};
  assign outside = (pix_x == 10'h3FF) || (pix_y == 10'h3FF) || (px >= H_W) || (py >= V_W);
  assign in_sq   = (px >= sx) && (px < sx + SQ_W) && (py >= sy) && (py < sy + SQ_W);

  always_comb begin
    pix_nxt = bg;
    if (outside)    pix_nxt = 16'h0000;
    else if (in_sq) pix_nxt = palette(cidx);
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) pix_data <= '0;
    else            pix_data <= pix_nxt;
  end

endmodule
